// File: rtl/lsu_mem_stage.sv
// RV32I/RV64I MEM stage: issues byte-enabled accesses to a variable-latency data bus,
// extends load data, flags misaligned/unsupported ops and times out a silent bus.

module lsu_byte_lane #(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2,
  parameter int LANE  = 0
) (
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic [XLEN-1:0]  data,
  output logic             be,
  output logic [7:0]       byte_out
);
  int nbytes, base;

  // Access is naturally aligned, so the lane's byte within the access is LANE mod size.
  always_comb begin
    nbytes   = 1 << size;
    base     = int'(off);
    be       = (LANE >= base) && (LANE < base + nbytes);
    byte_out = data[(LANE % nbytes)*8 +: 8];
  end
endmodule

module lsu_mem_stage #(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clk_en,
  input  logic               i_ex_valid,
  input  logic               i_ex_mem_rd,
  input  logic               i_ex_mem_wr,
  input  logic [2:0]         i_ex_funct3,
  input  logic [XLEN-1:0]    i_ex_alu_result,
  input  logic [XLEN-1:0]    i_ex_reg_read_data2,
  input  logic [REG_W-1:0]   i_ex_reg_dest,
  input  logic               i_ex_reg_wr,
  input  logic               i_ex_mem_to_reg,
  input  logic [1:0]         i_ex_rw_sel,
  input  logic [XLEN-1:0]    i_ex_pc_plus_4,
  output logic               o_data_req,
  output logic               o_data_we,
  output logic [XLEN-1:0]    o_data_addr,
  output logic [XLEN/8-1:0]  o_data_be,
  output logic [XLEN-1:0]    o_data_wr,
  input  logic               i_data_ack,
  input  logic [XLEN-1:0]    i_data_rd,
  output logic               o_stall,
  output logic               o_ma_valid,
  output logic               o_ma_reg_wr,
  output logic               o_ma_mem_to_reg,
  output logic [1:0]         o_ma_rw_sel,
  output logic [REG_W-1:0]   o_ma_reg_dest,
  output logic [XLEN-1:0]    o_ma_pc_plus_4,
  output logic [XLEN-1:0]    o_ma_result,
  output logic [XLEN-1:0]    o_ma_read_data,
  output logic [1:0]         o_fault
);
  localparam int NB    = XLEN/8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  typedef enum logic [0:0] {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  pc_plus_4;
    logic [REG_W-1:0] reg_dest;
    logic [1:0]       rw_sel;
    logic             mem_to_reg;
    logic             reg_wr;
  } wb_ctrl_t;

  state_t state, state_nx;
  wb_ctrl_t ex_ctrl, pend, ma;
  logic [7:0] wait_cnt;
  logic r_load;
  logic [2:0] r_funct3;
  logic [OFF_W-1:0] r_off;

  logic is_mem, unsup, misal, accept, timeout;
  logic [1:0] size, mem_fault;
  logic [OFF_W-1:0] off;
  logic [NB-1:0] be_n;
  logic [NB-1:0][7:0] wr_n;
  logic [XLEN-1:0] lane_sh, ld_ext;
  int w;
  logic sgn;

  assign ex_ctrl = '{result: i_ex_alu_result, pc_plus_4: i_ex_pc_plus_4,
                     reg_dest: i_ex_reg_dest, rw_sel: i_ex_rw_sel,
                     mem_to_reg: i_ex_mem_to_reg, reg_wr: i_ex_reg_wr};

  assign is_mem = i_ex_mem_rd | i_ex_mem_wr;
  assign size   = i_ex_funct3[1:0];
  assign off    = i_ex_alu_result[OFF_W-1:0];

  always_comb begin
    unsup = (i_ex_funct3 == 3'b111)
          | ((XLEN == 32) && (i_ex_funct3 == 3'b011 || i_ex_funct3 == 3'b110))
          | (i_ex_mem_wr & i_ex_funct3[2]);
    unique case (size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = i_ex_alu_result[0];
      2'b10:   misal = |i_ex_alu_result[1:0];
      default: misal = |i_ex_alu_result[2:0];
    endcase
    // Unsupported outranks misaligned: alignment is meaningless for an unknown size.
    if (!is_mem)    mem_fault = 2'b00;
    else if (unsup) mem_fault = 2'b10;
    else if (misal) mem_fault = 2'b01;
    else            mem_fault = 2'b00;
  end

  assign accept  = (state == IDLE) & i_ex_valid & is_mem & (mem_fault == 2'b00);
  assign timeout = (state == ACCESS) & ~i_data_ack & (wait_cnt == MAX_W8);

  for (genvar g = 0; g < NB; g++) begin : g_lane
    lsu_byte_lane #(.XLEN(XLEN), .OFF_W(OFF_W), .LANE(g)) u_lane (
      .off      (off),
      .size     (size),
      .data     (i_ex_reg_read_data2),
      .be       (be_n[g]),
      .byte_out (wr_n[g])
    );
  end

  always_comb begin
    lane_sh = i_data_rd >> {r_off, 3'b000};
    w = 8 << r_funct3[1:0];
    if (w > XLEN) w = XLEN;
    sgn = ~r_funct3[2] & lane_sh[w-1];
    ld_ext = lane_sh;
    for (int i = 0; i < XLEN; i++)
      if (i >= w) ld_ext[i] = sgn;
  end

  always_comb begin
    state_nx = state;
    if (i_clk_en) begin
      unique case (state)
        IDLE:    if (accept) state_nx = ACCESS;
        ACCESS:  if (i_data_ack || timeout) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt       <= '0;
      pend           <= '0;
      ma             <= '0;
      o_ma_valid     <= 1'b0;
      o_fault        <= 2'b00;
      o_ma_read_data <= '0;
      o_data_we      <= 1'b0;
      o_data_addr    <= '0;
      o_data_be      <= '0;
      o_data_wr      <= '0;
      r_load         <= 1'b0;
      r_funct3       <= 3'b000;
      r_off          <= '0;
    end else if (i_clk_en) begin
      unique case (state)
        IDLE: begin
          o_ma_valid <= 1'b0;
          o_fault    <= 2'b00;
          if (accept) begin
            pend        <= ex_ctrl;
            o_data_we   <= i_ex_mem_wr;
            o_data_addr <= {i_ex_alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            o_data_be   <= be_n;
            o_data_wr   <= wr_n;
            r_load      <= i_ex_mem_rd;
            r_funct3    <= i_ex_funct3;
            r_off       <= off;
            wait_cnt    <= '0;
          end else if (i_ex_valid) begin
            // Non-memory op or faulting access retires next cycle without a bus request.
            ma         <= ex_ctrl;
            ma.reg_wr  <= i_ex_reg_wr & ~is_mem;
            o_ma_valid <= 1'b1;
            o_fault    <= mem_fault;
          end
        end
        ACCESS: begin
          o_ma_valid <= 1'b0;
          o_fault    <= 2'b00;
          if (i_data_ack) begin
            ma         <= pend;
            o_ma_valid <= 1'b1;
            if (r_load) o_ma_read_data <= ld_ext;
          end else if (timeout) begin
            ma         <= pend;
            ma.reg_wr  <= 1'b0;
            o_ma_valid <= 1'b1;
            o_fault    <= 2'b11;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data_req      = (state == ACCESS);
  assign o_stall         = ~i_rst & (accept | ((state == ACCESS) & ~(i_data_ack & i_clk_en)));
  assign o_ma_reg_wr     = ma.reg_wr;
  assign o_ma_mem_to_reg = ma.mem_to_reg;
  assign o_ma_rw_sel     = ma.rw_sel;
  assign o_ma_reg_dest   = ma.reg_dest;
  assign o_ma_pc_plus_4  = ma.pc_plus_4;
  assign o_ma_result     = ma.result;
endmodule
